// File: rtl/edge_window_ctrl.sv
// Raster-stream sequencer for the 5x5 vertical-edge kernel:
// four line buffers feed a sliding window, results leave on valid/ready.
module edge_window_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CW    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   in_pixel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [199:0] window_out,
  input  logic [7:0]   kernel_pixel,
  output logic [7:0]   out_pixel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     col_q, col_d;
  logic [CW-1:0]     row_q, row_d;
  logic              last_q, last_d;
  logic              ov_q, ov_d;
  logic [24:0][7:0]  win_q, win_d;
  logic [7:0]        lb_q [4][IMG_W];

  logic [AW-1:0]     cidx;
  logic              accept;
  logic              complete;

  assign cidx     = col_q[AW-1:0];
  assign in_ready = (state_q == S_RUN) && (!ov_q || out_ready) && !last_q;
  assign accept   = in_valid && in_ready;
  assign complete = (row_q >= CW'(4)) && (col_q >= CW'(4));

  assign window_out = win_q;
  assign out_pixel  = kernel_pixel;
  assign out_valid  = ov_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    last_d  = last_q;
    ov_d    = ov_q;
    win_d   = win_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
          last_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (ov_q && out_ready) begin
          ov_d = 1'b0;
          if (last_q) state_d = S_DONE;
        end
        if (accept) begin
          for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
              win_d[5*r+c] = win_q[5*r+c+1];
            end
            win_d[5*r+4] = (r < 4) ? lb_q[r][cidx] : in_pixel;
          end
          if (complete) ov_d = 1'b1;
          if (col_q == CW'(IMG_W-1)) begin
            col_d = '0;
            if (row_q == CW'(IMG_H-1)) begin
              row_d  = '0;
              last_d = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      last_q  <= 1'b0;
      ov_q    <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      last_q  <= last_d;
      ov_q    <= ov_d;
      win_q   <= win_d;
    end
  end

  // Line buffers are never cleared: a new frame rewrites rows 0..3 first.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][cidx] <= lb_q[1][cidx];
      lb_q[1][cidx] <= lb_q[2][cidx];
      lb_q[2][cidx] <= lb_q[3][cidx];
      lb_q[3][cidx] <= in_pixel;
    end
  end

endmodule

// File: tb/tb_edge_window_ctrl.sv
// Directed bench for edge_window_ctrl on an 8x6 image with a
// behavioural Y-gradient kernel attached to window_out.
module tb_edge_window_ctrl;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int N    = W * H;
  localparam int NOUT = (W - 4) * (H - 4);
  localparam int LIM  = 1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [7:0]   in_pixel;
  logic         in_valid;
  logic         in_ready;
  logic [199:0] window_out;
  logic [7:0]   kernel_pixel;
  logic [7:0]   out_pixel;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edge_window_ctrl #(
    .IMG_W(W),
    .IMG_H(H),
    .CW(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .in_pixel(in_pixel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .window_out(window_out),
    .kernel_pixel(kernel_pixel),
    .out_pixel(out_pixel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .done(done)
  );

  function automatic int wr(input int i);
    case (i)
      0: return -1;
      1: return -2;
      2: return 0;
      3: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int wc(input int i);
    case (i)
      0: return 1;
      1: return 4;
      2: return 6;
      3: return 4;
      default: return 1;
    endcase
  endfunction

  // Y-gradient, saturated to 0..255
  function automatic logic [7:0] kern(input logic [199:0] w);
    int s;
    int b;
    s = 0;
    for (int rr = 0; rr < 5; rr++) begin
      for (int cc = 0; cc < 5; cc++) begin
        b = int'(w[8*(5*rr+cc) +: 8]);
        s += wr(rr) * wc(cc) * b;
      end
    end
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s[7:0];
  endfunction

  always_comb kernel_pixel = kern(window_out);

  function automatic logic [7:0] pix(input int mode, input int idx);
    int r;
    int c;
    int v;
    r = idx / W;
    c = idx % W;
    case (mode)
      0: v = 100;
      1: v = r;
      2: v = r * 8 + c;
      default: v = 50;
    endcase
    return v[7:0];
  endfunction

  function automatic logic [199:0] exp_win(input int mode, input int k);
    logic [199:0] w;
    int r0;
    int c0;
    r0 = k / (W - 4);
    c0 = k % (W - 4);
    w = '0;
    for (int rr = 0; rr < 5; rr++)
      for (int cc = 0; cc < 5; cc++)
        w[8*(5*rr+cc) +: 8] = pix(mode, (r0 + rr) * W + c0 + cc);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [199:0] got,
                     input logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic run_frame(input int mode, input bit gaps,
                           input bit rnd_rdy, input bit stall,
                           input int abort_at, input bit poke);
    int pix_idx;
    int out_idx;
    int stall_n;
    bit ov;
    bit stall_now;
    bit fin;
    logic [199:0] held_w;
    logic [7:0]   held_p;
    pix_idx = 0;
    out_idx = 0;
    stall_n = 0;
    fin     = 1'b0;
    held_w  = '0;
    held_p  = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 chk("busy_up", busy, 1'b1);
    for (int cyc = 0; cyc < LIM; cyc++) begin
      ov        = out_valid;
      stall_now = stall && ov && (out_idx == 0) && (stall_n < 5);
      out_ready = stall_now ? 1'b0 :
                  rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
      in_valid  = (pix_idx >= N) ? 1'b1 :
                  gaps ? 1'($urandom_range(1)) : 1'b1;
      in_pixel  = (pix_idx < N) ? pix(mode, pix_idx) : 8'hEE;
      start     = poke && (pix_idx == 10);
      #1;
      if (stall_now) begin
        stall_n++;
        chk("stall_in_ready", in_ready, 1'b0);
        if (stall_n == 1) begin
          held_w = window_out;
          held_p = out_pixel;
        end else begin
          chk("stall_window", window_out, held_w);
          chk("stall_pixel", out_pixel, held_p);
        end
      end
      if (pix_idx == N) chk("no_extra_accept", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        chk($sformatf("win%0d", out_idx), window_out,
            exp_win(mode, out_idx));
        chk($sformatf("pix%0d", out_idx), out_pixel,
            kern(exp_win(mode, out_idx)));
        out_idx++;
      end
      if (in_valid && in_ready) pix_idx++;
      if (abort_at > 0 && pix_idx == abort_at) begin
        fin = 1'b1;
        break;
      end
      if (out_idx == NOUT) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("frame_timeout", fin, 1'b1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (abort_at > 0) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
    end else begin
      #1;
      chk("accepts", pix_idx, N);
      chk("done_pulse", done, 1'b1);
      chk("done_busy", busy, 1'b0);
      chk("done_in_ready", in_ready, 1'b0);
      @(negedge clk);
      #1;
      chk("done_clear", done, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_pixel  = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid0", out_valid, 1'b0);
    chk("rst_done0", done, 1'b0);
    chk("rst_busy0", busy, 1'b0);
    chk("rst_in_ready0", in_ready, 1'b0);
    chk("rst_window0", window_out, '0);

    run_frame(0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_frame(1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_frame(2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_frame(2, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run_frame(2, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    run_frame(2, 1'b0, 1'b0, 1'b0, 20, 1'b0);
    run_frame(3, 1'b0, 1'b0, 1'b0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_window_ctrl.md
Name: edge_window_ctrl

Overview:
- Sequences the 5x5 combinational vertical-edge kernel (Y-gradient, 200-bit window in, 8-bit pixel out) over a raster-order 8-bit image stream.
- Keeps four line buffers and a 5x5 window register, and presents one complete window per accepted pixel to the external kernel instance.
- Returns the kernel result on a valid/ready output stream.
- Sits between the upsampled Y-plane output and the edge-map writer.

Parameters:
- IMG_W, 64, image width in pixels (>=5).
- IMG_H, 64, image height in pixels (>=5).
- CW, 16, column/row counter width (must hold IMG_W and IMG_H).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse; begins a frame when idle
- in_pixel  in  8  input pixel, raster order
- in_valid  in  1  in_pixel valid
- in_ready  out  1  controller accepts in_pixel this cycle
- window_out  out  200  5x5 window to kernel; byte index 5*r+c at [8*(5r+c)+7 : 8*(5r+c)]; r=0 is the oldest (top) row, c=0 is the leftmost column
- kernel_pixel  in  8  kernel result computed from window_out
- out_pixel  out  8  edge output (equals kernel_pixel)
- out_valid  out  1  out_pixel valid
- out_ready  in  1  downstream accepts out_pixel
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last output handshake

Behaviour:
- Clock is clk. Reset is synchronous, active-low on rst_n.
- Reset values:
  - state=IDLE
  - col=row=0
  - out_valid=0, done=0, busy=0, in_ready=0
  - window register all zero
  - line buffer contents not cleared; fill overwrites them before use.
- States:
  - IDLE: start=1 -> RUN. Clears col and row. busy=1 from the next cycle.
  - RUN: accepts pixels. After the handshake on the final output -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- start outside IDLE is ignored.
- in_ready = (state==RUN) && (!out_valid || out_ready) && pixels_accepted < IMG_W*IMG_H.
- Accept = in_valid && in_ready. On accept at position (row, col):
  - Window shifts left one column. New column c=4 holds rows r=0..3 from line buffers lb0..lb3[col] (lb0 oldest), and row r=4 = in_pixel.
  - Line buffers shift vertically at index col: lb0<=lb1, lb1<=lb2, lb2<=lb3, lb3<=in_pixel. Reads use pre-update values.
  - col increments. When col reaches IMG_W-1 it wraps to 0 and row increments.
  - The window is not cleared at row wrap. Columns left over from the previous row are flushed because windows are only valid once col>=4.
- Window completion:
  - An accept with row>=4 and col>=4 completes a valid window.
  - out_valid is set in the next cycle. window_out holds that window, and out_pixel=kernel_pixel from it.
  - Latency: one clock from the accept to out_valid.
  - No padding: windows touching the border are never emitted.
  - Outputs per frame = (IMG_W-4)*(IMG_H-4).
- Output handshake:
  - out_valid stays high and window_out stays stable until out_valid && out_ready.
  - in_ready stays low while out_valid && !out_ready, so no window is overwritten.
  - Simultaneous output handshake and new completing accept: out_valid stays 1 and presents the new window. Throughput is one pixel per clock.
- Arithmetic: counters are unsigned and wrap only at IMG_W-1 and IMG_H-1. No pixel arithmetic in this block; out_pixel is passed through.
- Frame end:
  - After IMG_W*IMG_H accepts, in_ready=0.
  - The final window's output handshake -> DONE.
  - Extra in_valid after the frame is not accepted.
- Reset mid-frame:
  - Immediate return to IDLE, and the pending output is dropped (out_valid=0).
  - The next frame produces only its own windows; stale line-buffer data never reaches a valid window.

Test Plan:
- IMG_W=8, IMG_H=6, constant pixel 100, real kernel attached, out_ready=1 -> exactly 8 outputs, each 0x00. done pulses once, the cycle after the 8th handshake. busy is 0 afterward.
- Same size, pixel = row index -> first window_out bytes 0..4=0, bytes 20..24=4. Every out_pixel = 128 (row weights -1,-2,0,2,1 give 8; times column weight sum 16).
- Pixel = row*8+col, 8x6 -> first output window byte 5*r+c = r*8+c. Second output window is shifted by +1. Fifth output window's byte 0 = 8 (row 1, col 0).
- Hold out_ready=0 for 5 cycles on the first output -> in_ready=0 and window_out/out_pixel constant during the stall. Still 8 outputs in order, no pixel lost.
- Random in_valid gaps (50%) plus random out_ready -> output sequence identical to the gap-free run.
- Assert rst_n=0 for 1 cycle after 20 accepts, then start a new constant-50 frame -> exactly 8 outputs, all 0. start pulsed while busy is ignored.
